// File: rtl/if_window_controller.sv
// IF window controller: walks a stored input-feature row in a circular scratchpad and produces
// one filter-window read sequence per output. Each window clears the MAC, reads filt_len taps,
// and pushes one psum. Windows step by stride until the next one would pass the row end.
module if_window_controller #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FLEN_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] row_start,
  input  logic [ADDR_W-1:0] row_end,
  input  logic [FLEN_W-1:0] filt_len,
  input  logic [FLEN_W-1:0] stride,
  input  logic              psum_full,
  output logic              sp_ren,
  output logic [ADDR_W-1:0] sp_raddr,
  output logic [FLEN_W-1:0] filt_raddr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              psum_valid,
  output logic              row_done,
  output logic              busy
);

  // Wide enough that off + stride + filt_len cannot overflow.
  localparam int unsigned SumW = ((ADDR_W > FLEN_W) ? ADDR_W : FLEN_W) + 3;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRead,
    StDrain,
    StEmit,
    StAdvance,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [FLEN_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] row_start_q, row_start_d;
  logic [ADDR_W-1:0] row_end_q, row_end_d;
  logic [FLEN_W-1:0] filt_len_q, filt_len_d;
  logic [FLEN_W-1:0] stride_q, stride_d;
  logic              mac_en_q;

  logic [SumW-1:0]   len_in;
  logic [SumW-1:0]   len_q;
  logic [ADDR_W-1:0] off;
  logic [SumW-1:0]   next_reach;

  // Row length ((end - start) mod 2^ADDR_W) + 1, zero-extended.
  function automatic logic [SumW-1:0] row_len(input logic [ADDR_W-1:0] s,
                                              input logic [ADDR_W-1:0] e);
    logic [ADDR_W-1:0] d;
    d = e - s;
    return SumW'(d) + SumW'(1);
  endfunction

  assign len_in     = row_len(row_start, row_end);
  assign len_q      = row_len(row_start_q, row_end_q);
  // Offset of the current window inside the row; the next window fits if its last tap is in range.
  assign off        = base_q - row_start_q;
  assign next_reach = SumW'(off) + SumW'(stride_q) + SumW'(filt_len_q);

  // State and latched row parameters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      k_q         <= '0;
      row_start_q <= '0;
      row_end_q   <= '0;
      filt_len_q  <= '0;
      stride_q    <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      k_q         <= k_d;
      row_start_q <= row_start_d;
      row_end_q   <= row_end_d;
      filt_len_q  <= filt_len_d;
      stride_q    <= stride_d;
    end
  end

  // mac_en follows sp_ren by one cycle to line up with the synchronous scratchpad read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_en_q <= 1'b0;
    end else begin
      mac_en_q <= sp_ren;
    end
  end

  assign mac_en = mac_en_q;
  assign busy   = (state_q != StIdle);

  // Next-state logic and per-state outputs.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    k_d         = k_q;
    row_start_d = row_start_q;
    row_end_d   = row_end_q;
    filt_len_d  = filt_len_q;
    stride_d    = stride_q;
    sp_ren      = 1'b0;
    sp_raddr    = '0;
    filt_raddr  = '0;
    mac_clr     = 1'b0;
    psum_valid  = 1'b0;
    row_done    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          row_start_d = row_start;
          row_end_d   = row_end;
          filt_len_d  = filt_len;
          stride_d    = stride;
          base_d      = row_start;
          k_d         = '0;
          // A row shorter than the filter produces no windows at all.
          state_d     = (len_in >= SumW'(filt_len)) ? StInit : StDone;
        end
      end
      StInit: begin
        mac_clr = 1'b1;
        state_d = StRead;
      end
      StRead: begin
        sp_ren     = 1'b1;
        sp_raddr   = base_q + ADDR_W'(k_q);
        filt_raddr = k_q;
        k_d        = k_q + FLEN_W'(1);
        if (k_q == filt_len_q - FLEN_W'(1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StEmit;
      end
      StEmit: begin
        // Back-pressure holds everything in place until the FIFO has room.
        if (!psum_full) begin
          psum_valid = 1'b1;
          state_d    = StAdvance;
        end
      end
      StAdvance: begin
        if (next_reach <= len_q) begin
          base_d  = base_q + ADDR_W'(stride_q);
          k_d     = '0;
          state_d = StInit;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        row_done = 1'b1;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule
